// File: rtl/rv_int_ctrl.sv
// Machine-level interrupt controller: ext-irq synchronizer, mtime/mtimecmp/msip
// register window, registered pending bits and a REQ/HOLD request FSM to the trap logic.
package rv_int_ctrl_pkg;
  typedef struct packed {
    logic enable_external;
    logic enable_timer;
    logic enable_soft;
  } int_ctrl_csr_t;

  typedef struct packed {
    logic pending_external;
    logic pending_timer;
    logic pending_soft;
  } int_ctrl_state_csr_t;
endpackage

module rv_int_ctrl
  import rv_int_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_ext_irq,
  input  logic                i_sel,
  input  logic [2:0]          i_idx,
  input  logic [31:0]         i_data,
  input  logic                i_write,
  output logic [31:0]         o_data,
  input  int_ctrl_csr_t       i_int_ctr,
  input  logic                i_mie,
  output int_ctrl_state_csr_t o_int_ctr_state,
  output logic                o_irq_req,
  output logic [31:0]         o_irq_cause,
  input  logic                i_irq_ack
);

  localparam logic [2:0] IDX_MSIP   = 3'd0;
  localparam logic [2:0] IDX_CMP_LO = 3'd1;
  localparam logic [2:0] IDX_CMP_HI = 3'd2;
  localparam logic [2:0] IDX_MT_LO  = 3'd3;
  localparam logic [2:0] IDX_MT_HI  = 3'd4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [3:0] CODE_MEI = 4'd11;
  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [63:0]            r_mtime;
  logic [63:0]            r_mtimecmp;
  logic                   r_msip;
  logic                   r_tpend;
  logic [1:0]             r_state;
  logic [31:0]            r_cause;

  logic                   w_wr;
  int_ctrl_state_csr_t    w_pend;
  int_ctrl_state_csr_t    w_act;
  logic                   w_fire;
  logic [3:0]             w_code;

  assign w_wr = i_sel & i_write;

  // Plain flop chain; the last stage is the pending_external bit itself.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_sync <= '0;
    else            r_sync <= {r_sync[SYNC_STAGES-2:0], i_ext_irq};
  end

  // A low-half write replaces the count for that cycle; a high-half write
  // still advances the low half, dropping its carry.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mtime <= '0;
    end else if (w_wr && i_idx == IDX_MT_LO) begin
      r_mtime <= {r_mtime[63:32], i_data};
    end else if (w_wr && i_idx == IDX_MT_HI) begin
      r_mtime <= {i_data, r_mtime[31:0] + 32'd1};
    end else begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
    end else if (w_wr) begin
      case (i_idx)
        IDX_MSIP:   r_msip             <= i_data[0];
        IDX_CMP_LO: r_mtimecmp[31:0]   <= i_data;
        IDX_CMP_HI: r_mtimecmp[63:32]  <= i_data;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_tpend <= 1'b0;
    else            r_tpend <= (r_mtime >= r_mtimecmp);
  end

  always_comb begin
    o_data = '0;
    if (i_sel) begin
      case (i_idx)
        IDX_MSIP:   o_data = {31'b0, r_msip};
        IDX_CMP_LO: o_data = r_mtimecmp[31:0];
        IDX_CMP_HI: o_data = r_mtimecmp[63:32];
        IDX_MT_LO:  o_data = r_mtime[31:0];
        IDX_MT_HI:  o_data = r_mtime[63:32];
        default:    o_data = '0;
      endcase
    end
  end

  assign w_pend.pending_external = r_sync[SYNC_STAGES-1];
  assign w_pend.pending_timer    = r_tpend;
  assign w_pend.pending_soft     = r_msip;
  assign o_int_ctr_state         = w_pend;

  assign w_act.pending_external = w_pend.pending_external & i_int_ctr.enable_external;
  assign w_act.pending_timer    = w_pend.pending_timer    & i_int_ctr.enable_timer;
  assign w_act.pending_soft     = w_pend.pending_soft     & i_int_ctr.enable_soft;
  assign w_fire = i_mie & (|w_act);

  always_comb begin
    w_code = CODE_MTI;
    if (w_act.pending_external)  w_code = CODE_MEI;
    else if (w_act.pending_soft) w_code = CODE_MSI;
  end

  // Cause is captured only on IDLE->REQ; REQ is held regardless of sources until ack.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_cause <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_fire) begin
          r_state <= S_REQ;
          r_cause <= {1'b1, 27'b0, w_code};
        end
        S_REQ:  if (i_irq_ack) r_state <= S_HOLD;
        S_HOLD: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_irq_req   = (r_state == S_REQ);
  assign o_irq_cause = r_cause;

endmodule

// File: tb/tb_rv_int_ctrl.sv
// Directed bench for rv_int_ctrl: inputs change on the falling edge, outputs are
// checked on the falling edge (or #1 later for combinational reads).
module tb_rv_int_ctrl;
  import rv_int_ctrl_pkg::*;

  logic                i_clk = 1'b0;
  logic                i_reset_n = 1'b0;
  logic                i_ext_irq = 1'b0;
  logic                i_sel = 1'b0;
  logic [2:0]          i_idx = '0;
  logic [31:0]         i_data = '0;
  logic                i_write = 1'b0;
  logic [31:0]         o_data;
  int_ctrl_csr_t       i_int_ctr = '0;
  logic                i_mie = 1'b0;
  int_ctrl_state_csr_t o_int_ctr_state;
  logic                o_irq_req;
  logic [31:0]         o_irq_cause;
  logic                i_irq_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  rv_int_ctrl #(.SYNC_STAGES(2)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ext_irq(i_ext_irq),
    .i_sel(i_sel), .i_idx(i_idx), .i_data(i_data), .i_write(i_write),
    .o_data(o_data), .i_int_ctr(i_int_ctr), .i_mie(i_mie),
    .o_int_ctr_state(o_int_ctr_state), .o_irq_req(o_irq_req),
    .o_irq_cause(o_irq_cause), .i_irq_ack(i_irq_ack)
  );

  always #5 i_clk = ~i_clk;

  // All tasks start and end just after a falling edge.
  task automatic wr(input logic [2:0] idx, input logic [31:0] d);
    i_sel = 1'b1; i_write = 1'b1; i_idx = idx; i_data = d;
    @(negedge i_clk);
    i_sel = 1'b0; i_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] idx, output logic [31:0] d);
    i_sel = 1'b1; i_idx = idx;
    #1 d = o_data;
    i_sel = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    repeat (3) @(negedge i_clk);
    checks++; if (o_irq_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", o_irq_req); end
    checks++; if (o_irq_cause !== 32'h0) begin failures++; $display("FAIL rst_cause got=%h exp=0", o_irq_cause); end
    checks++; if (o_int_ctr_state !== 3'b000) begin failures++; $display("FAIL rst_pend got=%b exp=000", o_int_ctr_state); end
    rd(3'd1, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_cmp_lo got=%h exp=ffffffff", d); end
    rd(3'd2, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_cmp_hi got=%h exp=ffffffff", d); end
    rd(3'd3, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_mtime got=%h exp=0", d); end
    i_idx = 3'd3;
    #1;
    checks++; if (o_data !== 32'h0) begin failures++; $display("FAIL sel0_data got=%h exp=0", o_data); end
    @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge i_clk);
      rd(3'd3, d);
      checks++; if (d !== 32'(k)) begin failures++; $display("FAIL mtime_inc got=%h exp=%h", d, k); end
    end
  endtask

  task automatic test_timer;
    logic [31:0] d;
    wr(3'd2, 32'h0);
    wr(3'd1, 32'h20);
    i_int_ctr = 3'b010; i_mie = 1'b1;
    wr(3'd3, 32'h10);
    rd(3'd3, d);
    checks++; if (d !== 32'h10) begin failures++; $display("FAIL tmr_wr got=%h exp=10", d); end
    repeat (16) @(negedge i_clk);
    rd(3'd3, d);
    checks++; if (d !== 32'h20) begin failures++; $display("FAIL tmr_count got=%h exp=20", d); end
    checks++; if (o_int_ctr_state.pending_timer !== 1'b0) begin failures++; $display("FAIL tmr_pend_early got=1 exp=0"); end
    @(negedge i_clk);
    checks++; if (o_int_ctr_state.pending_timer !== 1'b1 || o_irq_req !== 1'b0) begin
      failures++; $display("FAIL tmr_pend got=%b req=%b exp=1 req=0", o_int_ctr_state.pending_timer, o_irq_req); end
    @(negedge i_clk);
    checks++; if (o_irq_req !== 1'b1 || o_irq_cause !== 32'h8000_0007) begin
      failures++; $display("FAIL tmr_req got=%b/%h exp=1/80000007", o_irq_req, o_irq_cause); end
    i_irq_ack = 1'b1;
    @(negedge i_clk);
    i_irq_ack = 1'b0;
    checks++; if (o_irq_req !== 1'b0) begin failures++; $display("FAIL tmr_hold got=%b exp=0", o_irq_req); end
    @(negedge i_clk);
    checks++; if (o_irq_req !== 1'b0) begin failures++; $display("FAIL tmr_idle got=%b exp=0", o_irq_req); end
    @(negedge i_clk);
    checks++; if (o_irq_req !== 1'b1 || o_irq_cause !== 32'h8000_0007) begin
      failures++; $display("FAIL tmr_rereq got=%b/%h exp=1/80000007", o_irq_req, o_irq_cause); end
    i_irq_ack = 1'b1;
    @(negedge i_clk);
    i_irq_ack = 1'b0; i_int_ctr = 3'b000; i_mie = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_priority;
    i_mie = 1'b0;
    wr(3'd0, 32'h1);
    i_int_ctr = 3'b111; i_ext_irq = 1'b1;
    repeat (3) @(negedge i_clk);
    checks++; if (o_int_ctr_state !== 3'b111 || o_irq_req !== 1'b0) begin
      failures++; $display("FAIL pri_pend got=%b req=%b exp=111 req=0", o_int_ctr_state, o_irq_req); end
    i_mie = 1'b1;
    @(negedge i_clk);
    checks++; if (o_irq_req !== 1'b1 || o_irq_cause !== 32'h8000_000B) begin
      failures++; $display("FAIL pri_mei got=%b/%h exp=1/8000000b", o_irq_req, o_irq_cause); end
    i_irq_ack = 1'b1; i_ext_irq = 1'b0; i_mie = 1'b0;
    @(negedge i_clk);
    i_irq_ack = 1'b0; i_mie = 1'b1;
    @(negedge i_clk);
    checks++; if (o_irq_req !== 1'b0) begin failures++; $display("FAIL pri_gap got=%b exp=0", o_irq_req); end
    @(negedge i_clk);
    checks++; if (o_irq_req !== 1'b1 || o_irq_cause !== 32'h8000_0003) begin
      failures++; $display("FAIL pri_msi got=%b/%h exp=1/80000003", o_irq_req, o_irq_cause); end
    i_irq_ack = 1'b1; i_mie = 1'b0; i_int_ctr = 3'b000;
    @(negedge i_clk);
    i_irq_ack = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_gating;
    i_int_ctr = 3'b001; i_mie = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      checks++; if (o_irq_req !== 1'b0) begin failures++; $display("FAIL gate_mie got=%b exp=0", o_irq_req); end
    end
    i_int_ctr = 3'b000; i_mie = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      checks++; if (o_irq_req !== 1'b0) begin failures++; $display("FAIL gate_en got=%b exp=0", o_irq_req); end
    end
    i_int_ctr = 3'b001;
    @(negedge i_clk);
    checks++; if (o_irq_req !== 1'b1 || o_irq_cause !== 32'h8000_0003) begin
      failures++; $display("FAIL gate_open got=%b/%h exp=1/80000003", o_irq_req, o_irq_cause); end
    i_irq_ack = 1'b1; i_int_ctr = 3'b000; i_mie = 1'b0;
    @(negedge i_clk);
    i_irq_ack = 1'b0;
  endtask

  task automatic test_no_withdraw;
    wr(3'd0, 32'h0);
    i_int_ctr = 3'b100; i_mie = 1'b1; i_ext_irq = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++; if (o_irq_req !== 1'b0) begin failures++; $display("FAIL nw_early got=%b exp=0", o_irq_req); end
    @(negedge i_clk);
    checks++; if (o_irq_req !== 1'b1 || o_irq_cause !== 32'h8000_000B) begin
      failures++; $display("FAIL nw_req got=%b/%h exp=1/8000000b", o_irq_req, o_irq_cause); end
    i_ext_irq = 1'b0; i_mie = 1'b0; i_int_ctr = 3'b000;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      checks++; if (o_irq_req !== 1'b1 || o_irq_cause !== 32'h8000_000B) begin
        failures++; $display("FAIL nw_held got=%b/%h exp=1/8000000b", o_irq_req, o_irq_cause); end
    end
    i_irq_ack = 1'b1;
    @(negedge i_clk);
    i_irq_ack = 1'b0;
    checks++; if (o_irq_req !== 1'b0) begin failures++; $display("FAIL nw_ack got=%b exp=0", o_irq_req); end
    @(negedge i_clk);
  endtask

  task automatic test_wrap;
    logic [31:0] lo, hi;
    wr(3'd4, 32'hFFFF_FFFF);
    wr(3'd3, 32'hFFFF_FFFE);
    @(negedge i_clk);
    rd(3'd3, lo); rd(3'd4, hi);
    checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL wrap_max got=%h_%h exp=ffffffff_ffffffff", hi, lo); end
    @(negedge i_clk);
    rd(3'd3, lo); rd(3'd4, hi);
    checks++; if (lo !== 32'h0 || hi !== 32'h0) begin
      failures++; $display("FAIL wrap_zero got=%h_%h exp=00000000_00000000", hi, lo); end
  endtask

  task automatic test_reset_mid_req;
    logic [31:0] d;
    wr(3'd0, 32'h1);
    i_int_ctr = 3'b001; i_mie = 1'b1;
    @(negedge i_clk);
    checks++; if (o_irq_req !== 1'b1) begin failures++; $display("FAIL mr_req got=%b exp=1", o_irq_req); end
    #2 i_reset_n = 1'b0;
    #1;
    checks++; if (o_irq_req !== 1'b0 || o_irq_cause !== 32'h0) begin
      failures++; $display("FAIL mr_drop got=%b/%h exp=0/0", o_irq_req, o_irq_cause); end
    checks++; if (o_int_ctr_state !== 3'b000) begin failures++; $display("FAIL mr_pend got=%b exp=000", o_int_ctr_state); end
    @(negedge i_clk);
    i_reset_n = 1'b1;
    rd(3'd0, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL mr_msip got=%h exp=0", d); end
  endtask

  initial begin
    test_reset;
    test_timer;
    test_priority;
    test_gating;
    test_no_withdraw;
    test_wrap;
    test_reset_mid_req;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
